// File: rtl/qspi_pad_arbiter_if.sv
// Bundle of the two flash masters' pad-side signals plus the loader request/grant handshake.
// The masters drive through 'master'; the arbiter connects through 'slave'.
interface qspi_pad_arbiter_if;
    logic       soc_csb;
    logic       soc_sck;
    logic [3:0] soc_io_out;
    logic [3:0] soc_io_oeb;
    logic [3:0] soc_io_in;
    logic       soc_hold;

    logic       ldr_req;
    logic       ldr_gnt;
    logic       ldr_csb;
    logic       ldr_sck;
    logic [3:0] ldr_io_out;
    logic [3:0] ldr_io_oeb;
    logic [3:0] ldr_io_in;

    modport master (
        output soc_csb, soc_sck, soc_io_out, soc_io_oeb,
        output ldr_req, ldr_csb, ldr_sck, ldr_io_out, ldr_io_oeb,
        input  soc_io_in, soc_hold, ldr_gnt, ldr_io_in
    );

    modport slave (
        input  soc_csb, soc_sck, soc_io_out, soc_io_oeb,
        input  ldr_req, ldr_csb, ldr_sck, ldr_io_out, ldr_io_oeb,
        output soc_io_in, soc_hold, ldr_gnt, ldr_io_in
    );
endinterface

// File: rtl/qspi_pad_arbiter.sv
// Shares the QSPI flash pads between the SoC flash controller (default owner) and a flash loader.
// Ownership only moves once the SoC chip select has been idle, with a parked guard interval between owners.
module qspi_pad_arbiter #(
    parameter int GUARD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                aresetn,
    qspi_pad_arbiter_if.slave   bus,
    output logic                pad_csb_out,
    output logic                pad_csb_oeb,
    output logic                pad_sck_out,
    output logic                pad_sck_oeb,
    output logic [3:0]          pad_io_out,
    output logic [3:0]          pad_io_oeb,
    input  logic [3:0]          pad_io_in
);

    localparam int CNT_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        SOC_OWN,
        WAIT_SOC_IDLE,
        PARK_TO_LDR,
        LDR_OWN,
        PARK_TO_SOC
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             soc_hold_q;
    logic             ldr_gnt_q;

    logic             nxt_csb;
    logic             nxt_sck;
    logic [3:0]       nxt_io_out;
    logic [3:0]       nxt_io_oeb;

    assign cnt_inc = (idle_cnt == CNT_MAX) ? idle_cnt : idle_cnt + CNT_ONE;

    // Pad drive for the next cycle; anything not owned falls back to the parked value.
    always_comb begin
        nxt_csb    = 1'b1;
        nxt_sck    = 1'b0;
        nxt_io_out = 4'h0;
        nxt_io_oeb = 4'hF;
        case (state)
            SOC_OWN: begin
                nxt_csb    = bus.soc_csb;
                nxt_sck    = bus.soc_sck;
                nxt_io_out = bus.soc_io_out;
                nxt_io_oeb = bus.soc_io_oeb;
            end
            WAIT_SOC_IDLE: begin
                if (!bus.soc_csb) begin
                    nxt_csb    = bus.soc_csb;
                    nxt_sck    = bus.soc_sck;
                    nxt_io_out = bus.soc_io_out;
                    nxt_io_oeb = bus.soc_io_oeb;
                end
            end
            LDR_OWN: begin
                nxt_csb    = bus.ldr_csb;
                nxt_sck    = bus.ldr_sck;
                nxt_io_out = bus.ldr_io_out;
                nxt_io_oeb = bus.ldr_io_oeb;
            end
            default: ;
        endcase
    end

    // The guard counter doubles as the idle qualifier and the park timer.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= SOC_OWN;
            idle_cnt    <= '0;
            soc_hold_q  <= 1'b0;
            ldr_gnt_q   <= 1'b0;
            pad_csb_out <= 1'b1;
            pad_sck_out <= 1'b0;
            pad_io_out  <= 4'h0;
            pad_io_oeb  <= 4'hF;
        end else begin
            pad_csb_out <= nxt_csb;
            pad_sck_out <= nxt_sck;
            pad_io_out  <= nxt_io_out;
            pad_io_oeb  <= nxt_io_oeb;
            case (state)
                SOC_OWN: begin
                    if (bus.ldr_req) begin
                        state      <= WAIT_SOC_IDLE;
                        idle_cnt   <= '0;
                        soc_hold_q <= 1'b1;
                    end
                end
                WAIT_SOC_IDLE: begin
                    if (!bus.ldr_req) begin
                        state      <= SOC_OWN;
                        idle_cnt   <= '0;
                        soc_hold_q <= 1'b0;
                    end else if (!bus.soc_csb) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt >= CNT_LAST) begin
                        state    <= PARK_TO_LDR;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= cnt_inc;
                    end
                end
                PARK_TO_LDR: begin
                    if (idle_cnt >= CNT_LAST) begin
                        idle_cnt <= '0;
                        if (bus.ldr_req) begin
                            state     <= LDR_OWN;
                            ldr_gnt_q <= 1'b1;
                        end else begin
                            state <= PARK_TO_SOC;
                        end
                    end else begin
                        idle_cnt <= cnt_inc;
                    end
                end
                LDR_OWN: begin
                    if (!bus.ldr_req) begin
                        state     <= PARK_TO_SOC;
                        idle_cnt  <= '0;
                        ldr_gnt_q <= 1'b0;
                    end
                end
                PARK_TO_SOC: begin
                    if (idle_cnt >= CNT_LAST) begin
                        state      <= SOC_OWN;
                        idle_cnt   <= '0;
                        soc_hold_q <= 1'b0;
                    end else begin
                        idle_cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= SOC_OWN;
                end
            endcase
        end
    end

    assign pad_csb_oeb   = 1'b0;
    assign pad_sck_oeb   = 1'b0;
    assign bus.soc_hold  = soc_hold_q;
    assign bus.ldr_gnt   = ldr_gnt_q;
    assign bus.soc_io_in = (state == SOC_OWN || state == WAIT_SOC_IDLE) ? pad_io_in : 4'hF;
    assign bus.ldr_io_in = (state == LDR_OWN) ? pad_io_in : 4'hF;

endmodule

// File: tb/tb_qspi_pad_arbiter.sv
// Directed bench for qspi_pad_arbiter: a GUARD_CYCLES=4 instance for the main flows
// and a GUARD_CYCLES=1 instance for the minimum guard interval.
module tb_qspi_pad_arbiter;

    logic       clk = 1'b0;
    logic       aresetn = 1'b1;
    logic [3:0] pad_io_in;

    logic       pad_csb_out, pad_csb_oeb, pad_sck_out, pad_sck_oeb;
    logic [3:0] pad_io_out, pad_io_oeb;
    logic       pad1_csb_out, pad1_csb_oeb, pad1_sck_out, pad1_sck_oeb;
    logic [3:0] pad1_io_out, pad1_io_oeb;

    int total = 0;
    int bad = 0;

    qspi_pad_arbiter_if bus ();
    qspi_pad_arbiter_if bus1 ();

    qspi_pad_arbiter #(.GUARD_CYCLES(4)) dut (
        .clk(clk), .aresetn(aresetn), .bus(bus),
        .pad_csb_out(pad_csb_out), .pad_csb_oeb(pad_csb_oeb),
        .pad_sck_out(pad_sck_out), .pad_sck_oeb(pad_sck_oeb),
        .pad_io_out(pad_io_out), .pad_io_oeb(pad_io_oeb),
        .pad_io_in(pad_io_in)
    );

    qspi_pad_arbiter #(.GUARD_CYCLES(1)) dut1 (
        .clk(clk), .aresetn(aresetn), .bus(bus1),
        .pad_csb_out(pad1_csb_out), .pad_csb_oeb(pad1_csb_oeb),
        .pad_sck_out(pad1_sck_out), .pad_sck_oeb(pad1_sck_oeb),
        .pad_io_out(pad1_io_out), .pad_io_oeb(pad1_io_oeb),
        .pad_io_in(pad_io_in)
    );

    always #5 clk = ~clk;

    // Advance one active edge and settle, so outputs sampled next belong to that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic e;
        bus.soc_csb = 1'b0; bus.soc_sck = 1'b0; bus.soc_io_out = 4'hA; bus.soc_io_oeb = 4'h0;
        bus.ldr_req = 1'b0; bus.ldr_csb = 1'b1; bus.ldr_sck = 1'b0; bus.ldr_io_out = 4'h0; bus.ldr_io_oeb = 4'hF;
        bus1.soc_csb = 1'b1; bus1.soc_sck = 1'b0; bus1.soc_io_out = 4'h0; bus1.soc_io_oeb = 4'hF;
        bus1.ldr_req = 1'b0; bus1.ldr_csb = 1'b1; bus1.ldr_sck = 1'b0; bus1.ldr_io_out = 4'h0; bus1.ldr_io_oeb = 4'hF;
        pad_io_in = 4'h3;
        #2 aresetn = 1'b0;
        #1;
        total++; if (pad_csb_out !== 1'b1) begin bad++; $display("[TB] FAIL reset_csb got=%b exp=1", pad_csb_out); end
        total++; if (pad_io_oeb !== 4'hF) begin bad++; $display("[TB] FAIL reset_io_oeb got=%h exp=f", pad_io_oeb); end
        total++; if (pad_sck_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_sck got=%b exp=0", pad_sck_out); end
        total++; if ({pad_csb_oeb, pad_sck_oeb} !== 2'b00) begin bad++; $display("[TB] FAIL reset_ctl_oeb got=%b exp=00", {pad_csb_oeb, pad_sck_oeb}); end
        total++; if ({bus.ldr_gnt, bus.soc_hold} !== 2'b00) begin bad++; $display("[TB] FAIL reset_gnt_hold got=%b exp=00", {bus.ldr_gnt, bus.soc_hold}); end
        @(negedge clk);
        aresetn = 1'b1;
        tick();
        total++; if (pad_io_out !== 4'hA) begin bad++; $display("[TB] FAIL soc_io_out got=%h exp=a", pad_io_out); end
        total++; if (pad_io_oeb !== 4'h0) begin bad++; $display("[TB] FAIL soc_io_oeb got=%h exp=0", pad_io_oeb); end
        total++; if (pad_csb_out !== 1'b0) begin bad++; $display("[TB] FAIL soc_csb got=%b exp=0", pad_csb_out); end
        for (int i = 0; i < 4; i++) begin
            e = (i % 2 == 0);
            bus.soc_sck = e;
            tick();
            total++; if (pad_sck_out !== e) begin bad++; $display("[TB] FAIL soc_sck[%0d] got=%b exp=%b", i, pad_sck_out, e); end
        end
        total++; if (bus.ldr_io_in !== 4'hF) begin bad++; $display("[TB] FAIL idle_ldr_io_in got=%h exp=f", bus.ldr_io_in); end
        total++; if (bus.soc_io_in !== 4'h3) begin bad++; $display("[TB] FAIL idle_soc_io_in got=%h exp=3", bus.soc_io_in); end
        total++; if ({bus.ldr_gnt, bus.soc_hold} !== 2'b00) begin bad++; $display("[TB] FAIL idle_gnt_hold got=%b exp=00", {bus.ldr_gnt, bus.soc_hold}); end
    endtask

    task automatic test_handover();
        logic e;
        bus.ldr_req = 1'b1;
        bus.soc_io_out = 4'h1;
        tick();
        total++; if (bus.soc_hold !== 1'b1) begin bad++; $display("[TB] FAIL req_hold got=%b exp=1", bus.soc_hold); end
        for (int i = 2; i <= 4; i++) begin
            bus.soc_io_out = 4'(i);
            tick();
            total++; if (pad_io_out !== 4'(i) || pad_csb_out !== 1'b0) begin bad++; $display("[TB] FAIL wait_follow[%0d] got=%h/%b exp=%h/0", i, pad_io_out, pad_csb_out, 4'(i)); end
            total++; if (bus.ldr_gnt !== 1'b0) begin bad++; $display("[TB] FAIL wait_gnt[%0d] got=%b exp=0", i, bus.ldr_gnt); end
        end
        bus.soc_csb = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = (k == 8);
            total++; if (bus.ldr_gnt !== e) begin bad++; $display("[TB] FAIL gnt_timing[%0d] got=%b exp=%b", k, bus.ldr_gnt, e); end
            total++; if (pad_csb_out !== 1'b1 || pad_io_oeb !== 4'hF) begin bad++; $display("[TB] FAIL parked[%0d] got=%b/%h exp=1/f", k, pad_csb_out, pad_io_oeb); end
            total++; if (bus.soc_io_in !== ((k <= 3) ? 4'h3 : 4'hF)) begin bad++; $display("[TB] FAIL soc_ret[%0d] got=%h", k, bus.soc_io_in); end
            total++; if (bus.ldr_io_in !== (e ? 4'h3 : 4'hF)) begin bad++; $display("[TB] FAIL ldr_ret[%0d] got=%h", k, bus.ldr_io_in); end
        end
    endtask

    task automatic test_loader_own();
        logic e;
        bus.ldr_csb = 1'b0; bus.ldr_sck = 1'b1; bus.ldr_io_out = 4'hC; bus.ldr_io_oeb = 4'h0;
        pad_io_in = 4'h5;
        tick();
        total++; if ({pad_csb_out, pad_sck_out} !== 2'b01) begin bad++; $display("[TB] FAIL ldr_ctl got=%b exp=01", {pad_csb_out, pad_sck_out}); end
        total++; if (pad_io_out !== 4'hC || pad_io_oeb !== 4'h0) begin bad++; $display("[TB] FAIL ldr_io got=%h/%h exp=c/0", pad_io_out, pad_io_oeb); end
        total++; if (bus.ldr_io_in !== 4'h5) begin bad++; $display("[TB] FAIL ldr_io_in got=%h exp=5", bus.ldr_io_in); end
        total++; if (bus.soc_io_in !== 4'hF) begin bad++; $display("[TB] FAIL soc_io_in_blocked got=%h exp=f", bus.soc_io_in); end
        total++; if (bus.soc_hold !== 1'b1) begin bad++; $display("[TB] FAIL ldr_hold got=%b exp=1", bus.soc_hold); end
        bus.ldr_req = 1'b0;
        bus.soc_csb = 1'b0; bus.soc_io_out = 4'h6; bus.soc_io_oeb = 4'h0;
        tick();
        total++; if (bus.ldr_gnt !== 1'b0) begin bad++; $display("[TB] FAIL release_gnt got=%b exp=0", bus.ldr_gnt); end
        total++; if (pad_csb_out !== 1'b0 || pad_io_out !== 4'hC) begin bad++; $display("[TB] FAIL release_last_ldr got=%b/%h exp=0/c", pad_csb_out, pad_io_out); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            e = (k < 4);
            total++; if (bus.soc_hold !== e) begin bad++; $display("[TB] FAIL back_hold[%0d] got=%b exp=%b", k, bus.soc_hold, e); end
            total++; if (bus.soc_io_in !== (e ? 4'hF : 4'h5)) begin bad++; $display("[TB] FAIL back_soc_ret[%0d] got=%h", k, bus.soc_io_in); end
            total++; if (bus.ldr_io_in !== 4'hF) begin bad++; $display("[TB] FAIL back_ldr_ret[%0d] got=%h exp=f", k, bus.ldr_io_in); end
            if (k <= 4) begin
                total++; if (pad_csb_out !== 1'b1 || pad_io_oeb !== 4'hF) begin bad++; $display("[TB] FAIL back_parked[%0d] got=%b/%h exp=1/f", k, pad_csb_out, pad_io_oeb); end
            end else begin
                total++; if (pad_csb_out !== 1'b0 || pad_io_out !== 4'h6) begin bad++; $display("[TB] FAIL back_follow got=%b/%h exp=0/6", pad_csb_out, pad_io_out); end
            end
        end
    endtask

    task automatic test_abort_pulse();
        logic e;
        for (int k = 0; k < 6; k++) begin
            bus.ldr_req = (k < 2);
            bus.soc_io_out = 4'(k + 7);
            tick();
            e = (k < 2);
            total++; if (bus.soc_hold !== e) begin bad++; $display("[TB] FAIL abort_hold[%0d] got=%b exp=%b", k, bus.soc_hold, e); end
            total++; if (bus.ldr_gnt !== 1'b0) begin bad++; $display("[TB] FAIL abort_gnt[%0d] got=%b exp=0", k, bus.ldr_gnt); end
            total++; if (pad_csb_out !== 1'b0 || pad_io_out !== 4'(k + 7)) begin bad++; $display("[TB] FAIL abort_follow[%0d] got=%b/%h exp=0/%h", k, pad_csb_out, pad_io_out, 4'(k + 7)); end
        end
    endtask

    task automatic test_async_reset();
        int n;
        bus.soc_csb = 1'b1;
        bus.ldr_req = 1'b1;
        n = 0;
        while (bus.ldr_gnt !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        total++; if (bus.ldr_gnt !== 1'b1) begin bad++; $display("[TB] FAIL grant_timeout got=%b exp=1", bus.ldr_gnt); end
        bus.ldr_csb = 1'b0; bus.ldr_io_out = 4'h9; bus.ldr_io_oeb = 4'h0;
        tick();
        total++; if (pad_csb_out !== 1'b0 || pad_io_oeb !== 4'h0) begin bad++; $display("[TB] FAIL pre_reset_ldr got=%b/%h exp=0/0", pad_csb_out, pad_io_oeb); end
        #2 aresetn = 1'b0;
        #1;
        total++; if ({bus.ldr_gnt, bus.soc_hold} !== 2'b00) begin bad++; $display("[TB] FAIL async_gnt_hold got=%b exp=00", {bus.ldr_gnt, bus.soc_hold}); end
        total++; if (pad_csb_out !== 1'b1 || pad_io_oeb !== 4'hF) begin bad++; $display("[TB] FAIL async_pads got=%b/%h exp=1/f", pad_csb_out, pad_io_oeb); end
        total++; if (bus.ldr_io_in !== 4'hF) begin bad++; $display("[TB] FAIL async_ldr_ret got=%h exp=f", bus.ldr_io_in); end
        bus.ldr_req = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        bus.soc_csb = 1'b0; bus.soc_io_out = 4'h2; bus.soc_io_oeb = 4'h0;
        tick();
        total++; if (pad_io_out !== 4'h2 || pad_csb_out !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_follow got=%h/%b exp=2/0", pad_io_out, pad_csb_out); end
        total++; if ({bus.ldr_gnt, bus.soc_hold} !== 2'b00) begin bad++; $display("[TB] FAIL post_reset_gnt_hold got=%b exp=00", {bus.ldr_gnt, bus.soc_hold}); end
    endtask

    task automatic test_guard_one();
        logic e;
        bus1.soc_csb = 1'b1;
        bus1.ldr_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            e = (k == 3);
            total++; if (bus1.ldr_gnt !== e) begin bad++; $display("[TB] FAIL g1_gnt[%0d] got=%b exp=%b", k, bus1.ldr_gnt, e); end
            total++; if (bus1.soc_hold !== 1'b1) begin bad++; $display("[TB] FAIL g1_hold[%0d] got=%b exp=1", k, bus1.soc_hold); end
        end
        bus1.ldr_req = 1'b0;
        tick();
        total++; if ({bus1.ldr_gnt, bus1.soc_hold} !== 2'b01) begin bad++; $display("[TB] FAIL g1_release got=%b exp=01", {bus1.ldr_gnt, bus1.soc_hold}); end
        tick();
        total++; if (bus1.soc_hold !== 1'b0) begin bad++; $display("[TB] FAIL g1_back_hold got=%b exp=0", bus1.soc_hold); end
    endtask

    initial begin
        $display("[TB] starting qspi_pad_arbiter bench");
        test_reset();
        test_handover();
        test_loader_own();
        test_abort_pulse();
        test_async_reset();
        test_guard_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
